// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions for the ID/EX boundary.
//   ALU_OP_W       : width of the ALU operation code
//   REG_ADDR_W_DEF : default destination register address width
//   ex_ctrl_t      : execute-stage control bundle
//                    (alu_src, reg_write, mem_write, alu_op, dest)
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int ALU_OP_W       = 4;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic                      alu_src;
    logic                      reg_write;
    logic                      mem_write;
    logic [ALU_OP_W-1:0]       alu_op;
    logic [REG_ADDR_W_DEF-1:0] dest;
  } ex_ctrl_t;

endpackage : pipe_pkg

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the decode-side (in_*) and execute-side (out_*) handshake and
// payload of the ID/EX pipeline register.
//   slave  : used by id_ex_stage (consumes in_*, produces out_* and in_ready)
//   master : used by the surrounding pipeline / testbench
// Parameters WORD_SIZE and REG_ADDR_W must match those of id_ex_stage.
// -----------------------------------------------------------------------------
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
);

  // Decode -> stage
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_SIZE-1:0]  in_rs_data;
  logic [WORD_SIZE-1:0]  in_rt_data;
  logic [WORD_SIZE-1:0]  in_imm;
  logic                  in_alu_src;
  logic                  in_reg_write;
  logic                  in_mem_write;
  logic [ALU_OP_W-1:0]   in_alu_op;
  logic [REG_ADDR_W-1:0] in_dest;

  // Stage -> execute
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_SIZE-1:0]  out_rs_data;
  logic [WORD_SIZE-1:0]  out_rt_data;
  logic [WORD_SIZE-1:0]  out_imm;
  logic                  out_alu_src;
  logic                  out_reg_write;
  logic                  out_mem_write;
  logic [ALU_OP_W-1:0]   out_alu_op;
  logic [REG_ADDR_W-1:0] out_dest;

  modport slave (
    input  in_valid, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_reg_write, in_mem_write, in_alu_op, in_dest,
           out_ready,
    output in_ready,
           out_valid, out_rs_data, out_rt_data, out_imm,
           out_alu_src, out_reg_write, out_mem_write, out_alu_op, out_dest
  );

  modport master (
    output in_valid, in_rs_data, in_rt_data, in_imm,
           in_alu_src, in_reg_write, in_mem_write, in_alu_op, in_dest,
           out_ready,
    input  in_ready,
           out_valid, out_rs_data, out_rt_data, out_imm,
           out_alu_src, out_reg_write, out_mem_write, out_alu_op, out_dest
  );

endinterface : id_ex_stage_if

// File: rtl/id_ex_skid.sv
// -----------------------------------------------------------------------------
// id_ex_skid
// One-entry skid buffer holding an instruction accepted while the output
// register is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : empties the entry (wins over push/pop)
//   push_i     : write data_i into the entry
//   pop_i      : entry moved to the output register
//   data_i     : packed instruction to store
//   full_o     : entry occupied (registered)
//   data_o     : stored instruction
// -----------------------------------------------------------------------------
module id_ex_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic [W-1:0] data_o
);

  logic         full_q, full_d;
  logic [W-1:0] data_q;

  always_comb begin
    full_d = full_q;
    if (flush_i)     full_d = 1'b0;
    else if (push_i) full_d = 1'b1;
    else if (pop_i)  full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full_q <= 1'b0;
    else        full_q <= full_d;
  end

  // NOTE: the payload has no reset; it is only ever observed while full_q
  // is set, so clearing it would add reset fan-out for no visible effect.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) data_q <= data_i;
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule : id_ex_skid

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with valid/ready handshake on both sides.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset; clears all outputs, in_ready=1
//   flush : synchronous kill of held, buffered and incoming instructions
//   bus   : id_ex_stage_if.slave (in_* from decode, out_* to execute)
// out_alu_src selects the ALU B operand: 0 -> out_rt_data, 1 -> out_imm.
// out_reg_write / out_mem_write are forced low while out_valid is low so a
// bubble can never write; all other outputs hold their last value.
//
// Build option ID_EX_SKID_EN:
//   defined   : one-entry skid buffer (id_ex_skid); in_ready is registered
//               and equals "skid entry empty".
//   undefined : no skid; in_ready = !out_valid || out_ready (combinational).
// -----------------------------------------------------------------------------
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int WORD_SIZE  = 32,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic [WORD_SIZE-1:0]  rs_data;
    logic [WORD_SIZE-1:0]  rt_data;
    logic [WORD_SIZE-1:0]  imm;
    logic                  alu_src;
    logic                  reg_write;
    logic                  mem_write;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] dest;
  } entry_t;

  entry_t in_entry;
  entry_t out_q, out_d;
  logic   out_valid_q, out_valid_d;
  logic   in_xfer, out_xfer;

  assign in_entry = '{
    rs_data:   bus.in_rs_data,
    rt_data:   bus.in_rt_data,
    imm:       bus.in_imm,
    alu_src:   bus.in_alu_src,
    reg_write: bus.in_reg_write,
    mem_write: bus.in_mem_write,
    alu_op:    bus.in_alu_op,
    dest:      bus.in_dest
  };

`ifdef ID_EX_SKID_EN
  localparam int ENTRY_W = $bits(entry_t);

  logic   skid_full, skid_push, skid_pop;
  entry_t skid_data;

  id_ex_skid #(
    .W (ENTRY_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (skid_push),
    .pop_i   (skid_pop),
    .data_i  (in_entry),
    .full_o  (skid_full),
    .data_o  (skid_data)
  );

  // Registered ready: decode only ever sees a free skid slot, so an accepted
  // instruction always has somewhere to go even if execute stalls.
  assign bus.in_ready = !skid_full;
`else
  assign bus.in_ready = !out_valid_q || bus.out_ready;
`endif

  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = out_valid_q && bus.out_ready;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
`ifdef ID_EX_SKID_EN
    skid_push   = 1'b0;
    skid_pop    = 1'b0;
`endif
    if (flush) begin
      // Data is left untouched: only the valid bit (and skid flag) die.
      out_valid_d = 1'b0;
    end else begin
`ifdef ID_EX_SKID_EN
      if (skid_full) begin
        // A full skid implies the output register is occupied; the older
        // skid entry moves up as soon as execute takes the current one.
        if (out_xfer) begin
          out_d    = skid_data;
          skid_pop = 1'b1;
        end
      end else if (in_xfer) begin
        if (!out_valid_q || bus.out_ready) begin
          out_d       = in_entry;
          out_valid_d = 1'b1;
        end else begin
          skid_push = 1'b1;
        end
      end else if (out_xfer) begin
        out_valid_d = 1'b0;
      end
`else
      if (in_xfer) begin
        // Covers the simultaneous in/out transfer: replace, no bubble.
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else if (out_xfer) begin
        out_valid_d = 1'b0;
      end
`endif
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_rs_data   = out_q.rs_data;
  assign bus.out_rt_data   = out_q.rt_data;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_alu_src   = out_q.alu_src;
  assign bus.out_alu_op    = out_q.alu_op;
  assign bus.out_dest      = out_q.dest;
  assign bus.out_reg_write = out_valid_q && out_q.reg_write;
  assign bus.out_mem_write = out_valid_q && out_q.mem_write;

endmodule : id_ex_stage

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Self-checking bench for id_ex_stage: directed table of single-cycle vectors,
// hand-written multi-cycle sequences (bubble, mux feed, reset), then random
// traffic compared against a queue-based reference model.
// Works for both builds (ID_EX_SKID_EN defined or not).
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int WS = 32;
  localparam int RW = REG_ADDR_W_DEF;

`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef logic [127:0] wide_t;

  // Reference-model view of one instruction.
  typedef struct packed {
    logic [WS-1:0] rs;
    logic [WS-1:0] rt;
    logic [WS-1:0] imm;
    ex_ctrl_t      ctrl;
  } ent_t;

  // One directed vector: inputs for a cycle, in_ready expected before the
  // edge, and out_valid / out_reg_write / out_imm expected after it.
  typedef struct {
    logic        v;
    logic [31:0] imm;
    logic        ordy;
    logic        fl;
    logic        exp_rdy;
    logic        exp_ov;
    logic [31:0] exp_imm;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;

  always #5 clk = ~clk;

  id_ex_stage_if #(.WORD_SIZE(WS), .REG_ADDR_W(RW)) bus ();

  id_ex_stage #(.WORD_SIZE(WS), .REG_ADDR_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  ent_t q[$];
  ent_t shown;

  task automatic check(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl);
    bus.in_valid     = v;
    bus.in_rs_data   = e.rs;
    bus.in_rt_data   = e.rt;
    bus.in_imm       = e.imm;
    bus.in_alu_src   = e.ctrl.alu_src;
    bus.in_reg_write = e.ctrl.reg_write;
    bus.in_mem_write = e.ctrl.mem_write;
    bus.in_alu_op    = e.ctrl.alu_op;
    bus.in_dest      = e.ctrl.dest;
    bus.out_ready    = ordy;
    flush            = fl;
  endtask

  function automatic ent_t observed();
    ent_t o;
    o.rs             = bus.out_rs_data;
    o.rt             = bus.out_rt_data;
    o.imm            = bus.out_imm;
    o.ctrl.alu_src   = bus.out_alu_src;
    o.ctrl.reg_write = bus.out_reg_write;
    o.ctrl.mem_write = bus.out_mem_write;
    o.ctrl.alu_op    = bus.out_alu_op;
    o.ctrl.dest      = bus.out_dest;
    return o;
  endfunction

  task automatic add(input logic v, input logic [31:0] imm, input logic ordy, input logic fl,
                     input logic rdy, input logic ov, input logic [31:0] eimm);
    vec_t r;
    r.v = v; r.imm = imm; r.ordy = ordy; r.fl = fl;
    r.exp_rdy = rdy; r.exp_ov = ov; r.exp_imm = eimm;
    tbl.push_back(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t e;
    e = '0;
    rst_n = 1'b0;
    drive(1'b0, e, 1'b0, 1'b0);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", wide_t'({bus.in_ready, bus.out_valid, observed()}),
          wide_t'({1'b1, 1'b0, 108'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- directed table ----------------
    // Streaming: imm 1..8 back to back, one-cycle latency.
    for (int i = 1; i <= 8; i++) add(1'b1, 32'(i), 1'b1, 1'b0, 1'b1, 1'b1, 32'(i));
    add(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd8);
    // Stall: 0x10 held for three stalled cycles, 0x20 follows it.
    add(1'b1, 32'h10, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10);
    add(1'b1, 32'h20, 1'b0, 1'b0, SKID, 1'b1, 32'h10);
    add(!SKID, 32'h20, 1'b0, 1'b0, 1'b0, 1'b1, 32'h10);
    add(!SKID, 32'h20, 1'b1, 1'b0, !SKID, 1'b1, 32'h20);
    add(1'b0, 32'h20, 1'b1, 1'b0, 1'b1, 1'b0, 32'h20);
    // Flush with held instruction and 0x55 transferred in the same cycle.
    add(1'b1, 32'h44, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44);
    add(1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44);
    add(1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h44);
    // Flush while the skid (if present) is also occupied.
    add(1'b1, 32'h61, 1'b0, 1'b0, 1'b1, 1'b1, 32'h61);
    add(1'b1, 32'h62, 1'b0, 1'b0, SKID, 1'b1, 32'h61);
    add(1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h61);
    add(1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 1'b0, 32'h61);

    foreach (tbl[i]) begin
      e = '0;
      e.imm            = tbl[i].imm;
      e.rs             = ~tbl[i].imm;
      e.ctrl.reg_write = 1'b1;
      drive(tbl[i].v, e, tbl[i].ordy, tbl[i].fl);
      #1;
      check($sformatf("tbl%0d_in_ready", i), wide_t'(bus.in_ready), wide_t'(tbl[i].exp_rdy));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out", i),
            wide_t'({bus.out_valid, bus.out_reg_write, bus.out_imm}),
            wide_t'({tbl[i].exp_ov, tbl[i].exp_ov, tbl[i].exp_imm}));
    end

    // ---------------- bubble cannot write ----------------
    e = '0;
    e.imm            = 32'h77;
    e.ctrl.reg_write = 1'b1;
    e.ctrl.mem_write = 1'b1;
    drive(1'b0, e, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("bubble_no_write",
          wide_t'({bus.out_valid, bus.out_reg_write, bus.out_mem_write}), wide_t'(3'b000));

    // ---------------- ALU B-operand mux feed ----------------
    e = '0;
    e.rt             = 32'hAAAA0000;
    e.imm            = 32'h0000FFFF;
    e.ctrl.alu_src   = 1'b1;
    e.ctrl.reg_write = 1'b1;
    e.ctrl.alu_op    = 4'h9;
    e.ctrl.dest      = 5'd17;
    drive(1'b1, e, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("mux_feed", wide_t'({bus.out_valid, observed()}), wide_t'({1'b1, e}));
    drive(1'b1, e, 1'b0, 1'b0);

    // ---------------- asynchronous reset mid-cycle ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_mid_cycle", wide_t'({bus.in_ready, bus.out_valid, observed()}),
          wide_t'({1'b1, 1'b0, 108'd0}));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, e, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    check("post_reset_idle", wide_t'({bus.in_ready, bus.out_valid, observed()}),
          wide_t'({1'b1, 1'b0, 108'd0}));

    // ---------------- random traffic vs queue model ----------------
    q.delete();
    shown = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic v, ordy, fl, rdy;
      ent_t exp_e;
      v                = ($urandom_range(0, 9) < 7);
      ordy             = ($urandom_range(0, 9) < 6);
      fl               = ($urandom_range(0, 24) == 0);
      e.rs             = $urandom;
      e.rt             = $urandom;
      e.imm            = $urandom;
      e.ctrl.alu_src   = 1'($urandom);
      e.ctrl.reg_write = 1'($urandom);
      e.ctrl.mem_write = 1'($urandom);
      e.ctrl.alu_op    = 4'($urandom);
      e.ctrl.dest      = 5'($urandom);
      drive(v, e, ordy, fl);
      // Skid build: room while fewer than two are held. Otherwise: room if
      // empty or the held instruction leaves this cycle.
      rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
      #1;
      exp_e = shown;
      exp_e.ctrl.reg_write = shown.ctrl.reg_write && (q.size() > 0);
      exp_e.ctrl.mem_write = shown.ctrl.mem_write && (q.size() > 0);
      check($sformatf("rand%0d", cyc),
            wide_t'({bus.in_ready, bus.out_valid, observed()}),
            wide_t'({rdy, (q.size() > 0), exp_e}));
      @(posedge clk);
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (v && rdy) q.push_back(e);
      end
      if (q.size() > 0) shown = q[0];
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_id_ex_stage
